game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Parametrised game-state controller for the maze game. Replaces the ad-hoc reset/score logic.
//  Tracks N ghosts, lives, score, pellet count and power-pellet (frightened) mode, driven by a
//  movement tick enable instead of derived clocks. Sits between the sprite position-update units
//  and the video/BCD score path. Issues move_en, sprite_reset and per-ghost respawn pulses.
// PARAMETERS
//  NUM_GHOSTS    4     ghosts checked for collision (1..8)
//  POS_X_W       11    sprite x coordinate width
//  POS_Y_W       10    sprite y coordinate width
//  SCORE_W       12    score width, saturating
//  START_LIVES   3     lives loaded on new game (1..7)
//  HIT_RADIUS    8     collision when |dx|<HIT_RADIUS and |dy|<HIT_RADIUS (pixels)
//  FOOD_TOTAL    300   pellets per level
//  FRIGHT_TICKS  256   ticks of frightened mode per power pellet
//  READY_TICKS   32    ticks in READY before play
//  DEATH_TICKS   64    ticks in DYING
//  GHOST_POINTS  10    score added per ghost eaten
// PORTS
//  clk           in   1                      system clock
//  rst           in   1                      asynchronous reset, active-high
//  tick          in   1                      movement tick enable, 1-cycle pulse
//  start         in   1                      start/restart request (level)
//  pacman_x      in   POS_X_W                pacman position
//  pacman_y      in   POS_Y_W
//  ghost_x       in   NUM_GHOSTS*POS_X_W     ghost i at [i*POS_X_W +: POS_X_W]
//  ghost_y       in   NUM_GHOSTS*POS_Y_W
//  food_eaten    in   1                      pulse: normal pellet consumed
//  power_eaten   in   1                      pulse: power pellet consumed (scores as a pellet too)
//  state         out  3                      game_pkg state encoding
//  move_en       out  1                      tick & (state==PLAY); gates sprite updates
//  sprite_reset  out  1                      1-cycle pulse: reload all sprites to reset positions
//  ghost_respawn out  NUM_GHOSTS             1-cycle pulse per eaten ghost
//  frightened    out  1                      frightened mode active
//  lives         out  3                      remaining lives
//  score         out  SCORE_W                total score
//  game_over     out  1                      state==OVER
//  level_clear   out  1                      state==CLEAR
// BEHAVIOUR
//  Reset: state=IDLE, lives=START_LIVES, score=0, frightened=0, all pulses/counters 0.
//  FSM: IDLE -start-> READY(load lives/score/food cnt; sprite_reset pulse).
//   READY: count READY_TICKS ticks -> PLAY.  PLAY: see events.  DYING: DEATH_TICKS ticks, then
//   lives==0 -> OVER else sprite_reset pulse, -> READY.  OVER/CLEAR: start rising edge -> IDLE
//   path (CLEAR keeps score/lives, reloads food cnt; OVER full restart).
//  Collision: per-ghost hit computed combinationally, registered once (1-cycle latency); action
//   taken on cycle after registered hit, only in PLAY. Abs diff on unsigned coordinates, no wrap.
//  PLAY events, same cycle priority: hit by non-frightened ghost -> DYING, lives-1 (never below 0),
//   frightened cleared; else hits while frightened -> respawn pulse for every hit ghost,
//   score += popcount(hits)*GHOST_POINTS; pellets still counted in that cycle.
//  Mixed frightened/non-frightened hits cannot occur (frightened is global): any hit = eat.
//  food_eaten or power_eaten: score+1, food cnt+1; both in one cycle count once.
//  Food cnt reaching FOOD_TOTAL -> CLEAR on next cycle unless death in same cycle (death wins).
//  power_eaten: frightened=1, fright counter reloads FRIGHT_TICKS (reload if already active);
//   decrements on tick, clears at 0. Counter frozen outside PLAY.
//  Score saturates at 2^SCORE_W-1. Pellet/power pulses outside PLAY ignored.
//  move_en combinational from tick and registered state. rst mid-game: immediate IDLE.
// STRUCTURE
//  game_pkg: state encoding (IDLE,READY,PLAY,DYING,OVER,CLEAR), direction one-hot constants.
//  Sub-module hit_detect (one abs-diff compare per ghost), instantiated via generate x NUM_GHOSTS.
// TESTING
//  rst, start, 32 ticks -> state READY then PLAY, sprite_reset one pulse, lives=3, score=0.
//  PLAY, ghost1 at pacman+(4,4), not frightened -> DYING 2 cycles later, lives=2; 64 ticks -> READY.
//  power_eaten then ghosts 0,2 overlap pacman -> respawn=4'b0101, score +21, frightened stays 1.
//  FOOD_TOTAL=3: three food_eaten pulses -> score=3, level_clear; start -> READY, score kept 3.
//  Third death with lives=1 -> DYING then OVER, game_over=1; start -> IDLE/READY, lives=3, score=0.
//  Last pellet and lethal hit same cycle -> DYING, not CLEAR; score +1; rst mid-PLAY -> IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the maze game: game-state values and joystick directions.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4,
    ST_CLEAR = 3'd5
  } game_state_e;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

endpackage

// File: rtl/hit_detect.sv
// Box collision test between pacman and one ghost: |dx| < radius and |dy| < radius.
module hit_detect #(
  parameter int unsigned POS_X_W    = 11,
  parameter int unsigned POS_Y_W    = 10,
  parameter int unsigned HIT_RADIUS = 8
) (
  input  logic [POS_X_W-1:0] ax,
  input  logic [POS_Y_W-1:0] ay,
  input  logic [POS_X_W-1:0] bx,
  input  logic [POS_Y_W-1:0] by,
  output logic               hit
);

  localparam logic [POS_X_W:0] RAD_X = (POS_X_W + 1)'(HIT_RADIUS);
  localparam logic [POS_Y_W:0] RAD_Y = (POS_Y_W + 1)'(HIT_RADIUS);

  logic [POS_X_W-1:0] dx;
  logic [POS_Y_W-1:0] dy;

  // Unsigned absolute differences; screen coordinates never wrap.
  always_comb begin
    dx  = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy  = (ay >= by) ? (ay - by) : (by - ay);
    hit = ({1'b0, dx} < RAD_X) && ({1'b0, dy} < RAD_Y);
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game-state controller: lives, score, pellet count, frightened mode and sprite control pulses.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS   = 4,
  parameter int unsigned POS_X_W      = 11,
  parameter int unsigned POS_Y_W      = 10,
  parameter int unsigned SCORE_W      = 12,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned HIT_RADIUS   = 8,
  parameter int unsigned FOOD_TOTAL   = 300,
  parameter int unsigned FRIGHT_TICKS = 256,
  parameter int unsigned READY_TICKS  = 32,
  parameter int unsigned DEATH_TICKS  = 64,
  parameter int unsigned GHOST_POINTS = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          start,
  input  logic [POS_X_W-1:0]            pacman_x,
  input  logic [POS_Y_W-1:0]            pacman_y,
  input  logic [NUM_GHOSTS*POS_X_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*POS_Y_W-1:0] ghost_y,
  input  logic                          food_eaten,
  input  logic                          power_eaten,
  output logic [2:0]                    state,
  output logic                          move_en,
  output logic                          sprite_reset,
  output logic [NUM_GHOSTS-1:0]         ghost_respawn,
  output logic                          frightened,
  output logic [2:0]                    lives,
  output logic [SCORE_W-1:0]            score,
  output logic                          game_over,
  output logic                          level_clear
);

  localparam int unsigned TMAX   = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
  localparam int unsigned TCNT_W = $clog2(TMAX + 1);
  localparam int unsigned FOOD_W = $clog2(FOOD_TOTAL + 1);
  localparam int unsigned FR_W   = $clog2(FRIGHT_TICKS + 1);
  localparam int unsigned SUM_W  = SCORE_W + 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_e           state_q, state_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [FOOD_W-1:0]     food_q, food_d, food_inc;
  logic [FR_W-1:0]       fcnt_q, fcnt_d;
  logic                  fright_q, fright_d;
  logic [2:0]            lives_q, lives_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic                  keep_q, keep_d;
  logic                  start_q;
  logic                  sreset_q, sreset_d;
  logic [NUM_GHOSTS-1:0] hit_d, hit_q;
  logic [NUM_GHOSTS-1:0] resp_q, resp_d;
  logic                  over_q, clear_q;
  logic                  pellet, start_rise, any_hit;
  logic [3:0]            n_hits;
  logic [SUM_W-1:0]      pts, score_sum;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
    hit_detect #(
      .POS_X_W   (POS_X_W),
      .POS_Y_W   (POS_Y_W),
      .HIT_RADIUS(HIT_RADIUS)
    ) u_hit (
      .ax (pacman_x),
      .ay (pacman_y),
      .bx (ghost_x[g*POS_X_W +: POS_X_W]),
      .by (ghost_y[g*POS_Y_W +: POS_Y_W]),
      .hit(hit_d[g])
    );
  end

  // Next-state and datapath updates for the game FSM.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    food_d     = food_q;
    fcnt_d     = fcnt_q;
    fright_d   = fright_q;
    lives_d    = lives_q;
    score_d    = score_q;
    keep_d     = keep_q;
    sreset_d   = 1'b0;
    resp_d     = '0;
    pts        = '0;
    score_sum  = '0;
    pellet     = food_eaten | power_eaten;
    start_rise = start & ~start_q;
    any_hit    = |hit_q;
    n_hits     = '0;
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      n_hits = n_hits + 4'(hit_q[i]);
    end
    // Pellet count saturates at the level total so a level whose last pellet
    // coincided with a death still clears on the first PLAY cycle after respawn.
    food_inc = (food_q == FOOD_W'(FOOD_TOTAL)) ? food_q : food_q + FOOD_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READY;
          tcnt_d   = '0;
          food_d   = '0;
          fright_d = 1'b0;
          fcnt_d   = '0;
          sreset_d = 1'b1;
          keep_d   = 1'b0;
          if (!keep_q) begin
            lives_d = 3'(START_LIVES);
            score_d = '0;
          end
        end
      end
      ST_READY: begin
        if (tick) begin
          if (tcnt_q == TCNT_W'(READY_TICKS - 1)) begin
            state_d = ST_PLAY;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (pellet) food_d = food_inc;
        if (any_hit && !fright_q) begin
          state_d  = ST_DYING;
          tcnt_d   = '0;
          lives_d  = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          fright_d = 1'b0;
          fcnt_d   = '0;
        end else begin
          if (any_hit) begin
            resp_d = hit_q;
            pts    = SUM_W'(n_hits) * SUM_W'(GHOST_POINTS);
          end
          if (power_eaten) begin
            fright_d = 1'b1;
            fcnt_d   = FR_W'(FRIGHT_TICKS);
          end else if (fright_q && tick) begin
            fcnt_d = fcnt_q - FR_W'(1);
            if (fcnt_q == FR_W'(1)) fright_d = 1'b0;
          end
          if (food_d == FOOD_W'(FOOD_TOTAL)) state_d = ST_CLEAR;
        end
        score_sum = SUM_W'(score_q) + pts + SUM_W'(pellet);
        score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
      end
      ST_DYING: begin
        if (tick) begin
          if (tcnt_q == TCNT_W'(DEATH_TICKS - 1)) begin
            tcnt_d = '0;
            if (lives_q == 3'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d  = ST_READY;
              sreset_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          state_d = ST_IDLE;
          keep_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (start_rise) begin
          state_d = ST_IDLE;
          keep_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, registered outputs and the one-cycle collision pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= '0;
      food_q   <= '0;
      fcnt_q   <= '0;
      fright_q <= 1'b0;
      lives_q  <= 3'(START_LIVES);
      score_q  <= '0;
      keep_q   <= 1'b0;
      start_q  <= 1'b0;
      sreset_q <= 1'b0;
      resp_q   <= '0;
      hit_q    <= '0;
      over_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      food_q   <= food_d;
      fcnt_q   <= fcnt_d;
      fright_q <= fright_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      keep_q   <= keep_d;
      start_q  <= start;
      sreset_q <= sreset_d;
      resp_q   <= resp_d;
      hit_q    <= hit_d;
      over_q   <= (state_d == ST_OVER);
      clear_q  <= (state_d == ST_CLEAR);
    end
  end

  assign state         = state_q;
  assign move_en       = tick & (state_q == ST_PLAY);
  assign sprite_reset  = sreset_q;
  assign ghost_respawn = resp_q;
  assign frightened    = fright_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign game_over     = over_q;
  assign level_clear   = clear_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: directed game scenarios followed by random play.
module tb_game_state_ctrl;

  localparam int NG  = 4;
  localparam int XW  = 11;
  localparam int YW  = 10;
  localparam int SW  = 7;
  localparam int SL  = 3;
  localparam int HR  = 8;
  localparam int FT  = 3;
  localparam int FRT = 16;
  localparam int RT  = 32;
  localparam int DT  = 64;
  localparam int GP  = 10;
  localparam int SMAX = (1 << SW) - 1;

  localparam int M_IDLE = 0, M_READY = 1, M_PLAY = 2, M_DYING = 3, M_OVER = 4, M_CLEAR = 5;

  typedef struct {
    int          due;
    int          st;
    int          lives;
    int          score;
    bit          fr;
    logic [NG-1:0] resp;
    bit          sr;
    bit          go;
    bit          lc;
  } exp_t;

  typedef struct {
    int due;
    bit v;
  } me_t;

  logic clk = 1'b0;
  logic rst, tick, start, food_eaten, power_eaten;
  logic [XW-1:0]    pacman_x;
  logic [YW-1:0]    pacman_y;
  logic [NG*XW-1:0] ghost_x;
  logic [NG*YW-1:0] ghost_y;
  logic [2:0]       state;
  logic             move_en, sprite_reset, frightened, game_over, level_clear;
  logic [NG-1:0]    ghost_respawn;
  logic [2:0]       lives;
  logic [SW-1:0]    score;

  game_state_ctrl #(
    .NUM_GHOSTS  (NG),
    .POS_X_W     (XW),
    .POS_Y_W     (YW),
    .SCORE_W     (SW),
    .START_LIVES (SL),
    .HIT_RADIUS  (HR),
    .FOOD_TOTAL  (FT),
    .FRIGHT_TICKS(FRT),
    .READY_TICKS (RT),
    .DEATH_TICKS (DT),
    .GHOST_POINTS(GP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .pacman_x     (pacman_x),
    .pacman_y     (pacman_y),
    .ghost_x      (ghost_x),
    .ghost_y      (ghost_y),
    .food_eaten   (food_eaten),
    .power_eaten  (power_eaten),
    .state        (state),
    .move_en      (move_en),
    .sprite_reset (sprite_reset),
    .ghost_respawn(ghost_respawn),
    .frightened   (frightened),
    .lives        (lives),
    .score        (score),
    .game_over    (game_over),
    .level_clear  (level_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  me_t  me_q[$];

  int px, py;
  int gx[NG], gy[NG];

  // Reference model: game rules expressed with plain integers and countdowns.
  int m_st, m_lives, m_score, m_fr, m_frleft, m_eaten, m_wait, m_keep, m_prev_start;
  logic [NG-1:0] m_hits_prev;

  task automatic model_reset();
    m_st = M_IDLE; m_lives = SL; m_score = 0; m_fr = 0; m_frleft = 0;
    m_eaten = 0; m_wait = 0; m_keep = 0; m_prev_start = 0; m_hits_prev = '0;
  endtask

  function automatic logic [NG-1:0] hits_from_positions();
    logic [NG-1:0] h;
    int dx, dy;
    h = '0;
    for (int g = 0; g < NG; g++) begin
      dx = px - gx[g]; if (dx < 0) dx = -dx;
      dy = py - gy[g]; if (dy < 0) dy = -dy;
      h[g] = (dx < HR) && (dy < HR);
    end
    return h;
  endfunction

  function automatic exp_t snap(input logic [NG-1:0] resp, input bit sr);
    exp_t e;
    e.due = 0; e.st = m_st; e.lives = m_lives; e.score = m_score; e.fr = (m_fr != 0);
    e.resp = resp; e.sr = sr; e.go = (m_st == M_OVER); e.lc = (m_st == M_CLEAR);
    return e;
  endfunction

  task automatic model_step(input bit t, input bit s, input bit f, input bit p,
                            output logic [NG-1:0] resp, output bit sr);
    logic [NG-1:0] hits;
    int gain;
    hits = m_hits_prev;
    m_hits_prev = hits_from_positions();
    resp = '0; sr = 0; gain = 0;
    case (m_st)
      M_IDLE: if (s) begin
        m_st = M_READY; m_wait = RT; sr = 1;
        if (m_keep == 0) begin m_lives = SL; m_score = 0; end
        m_keep = 0; m_eaten = 0; m_fr = 0; m_frleft = 0;
      end
      M_READY: if (t) begin
        m_wait--;
        if (m_wait == 0) m_st = M_PLAY;
      end
      M_PLAY: begin
        if (f || p) begin
          gain = 1;
          if (m_eaten < FT) m_eaten++;
        end
        if (hits != 0 && m_fr == 0) begin
          m_st = M_DYING; m_wait = DT; m_fr = 0; m_frleft = 0;
          if (m_lives > 0) m_lives--;
        end else begin
          if (hits != 0) begin
            resp = hits;
            gain += GP * $countones(hits);
          end
          if (p) begin
            m_fr = 1; m_frleft = FRT;
          end else if (m_fr != 0 && t) begin
            m_frleft--;
            if (m_frleft == 0) m_fr = 0;
          end
          if (m_eaten == FT) m_st = M_CLEAR;
        end
        m_score = (m_score + gain > SMAX) ? SMAX : m_score + gain;
      end
      M_DYING: if (t) begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_lives == 0) m_st = M_OVER;
          else begin m_st = M_READY; m_wait = RT; sr = 1; end
        end
      end
      M_OVER:  if (s && m_prev_start == 0) begin m_st = M_IDLE; m_keep = 0; end
      M_CLEAR: if (s && m_prev_start == 0) begin m_st = M_IDLE; m_keep = 1; end
      default: m_st = M_IDLE;
    endcase
    m_prev_start = s;
  endtask

  // One stimulus cycle: drive inputs just after the edge and queue the expected response.
  task automatic cycle(input bit r, input bit t, input bit s, input bit f, input bit p);
    exp_t e;
    me_t  m;
    logic [NG-1:0] resp;
    bit sr;
    @(posedge clk); #1;
    pacman_x = px[XW-1:0];
    pacman_y = py[YW-1:0];
    for (int g = 0; g < NG; g++) begin
      ghost_x[g*XW +: XW] = gx[g][XW-1:0];
      ghost_y[g*YW +: YW] = gy[g][YW-1:0];
    end
    rst = r; tick = t; start = s; food_eaten = f; power_eaten = p;
    if (r) begin
      model_reset();
      e = snap('0, 0);
      // Asynchronous reset shows up before the next edge: the pending entry becomes reset values.
      if (exp_q.size() > 0) begin
        e.due = exp_q[exp_q.size()-1].due;
        exp_q[exp_q.size()-1] = e;
      end
      e.due = cyc + 1;
      exp_q.push_back(e);
      m.due = cyc; m.v = 0;
      me_q.push_back(m);
    end else begin
      m.due = cyc; m.v = t && (m_st == M_PLAY);
      me_q.push_back(m);
      model_step(t, s, f, p, resp, sr);
      e = snap(resp, sr);
      e.due = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic ghosts_far();
    for (int g = 0; g < NG; g++) begin
      gx[g] = 1000 + 200 * g;
      gy[g] = 600 + 100 * g;
    end
  endtask

  function automatic int clampv(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic die_once();
    gx[1] = px + 4; gy[1] = py + 4;
    cycle(0, 0, 0, 0, 0);
    ghosts_far();
    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (DT) cycle(0, 1, 0, 0, 0);
  endtask

  // Monitor: compare every due expectation against what the DUT presents mid-cycle.
  initial begin
    exp_t e;
    me_t  m;
    forever begin
      @(negedge clk);
      while (me_q.size() > 0 && me_q[0].due <= cyc) begin
        m = me_q.pop_front();
        check("move_en", 32'(move_en), 32'(m.v));
      end
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("lives", 32'(lives), 32'(e.lives));
        check("score", 32'(score), 32'(e.score));
        check("frightened", 32'(frightened), 32'(e.fr));
        check("ghost_respawn", 32'(ghost_respawn), 32'(e.resp));
        check("sprite_reset", 32'(sprite_reset), 32'(e.sr));
        check("game_over", 32'(game_over), 32'(e.go));
        check("level_clear", 32'(level_clear), 32'(e.lc));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; food_eaten = 1'b0; power_eaten = 1'b0;
    px = 100; py = 100;
    ghosts_far();
    pacman_x = '0; pacman_y = '0; ghost_x = '0; ghost_y = '0;
    model_reset();

    repeat (3) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (RT) cycle(0, 1, 0, 0, 0);

    // Unfrightened contact with ghost 1, then respawn back to PLAY.
    die_once();
    repeat (RT) cycle(0, 1, 0, 0, 0);

    // Power pellet, then ghosts 0 and 2 inside the radius; ghost 3 exactly on the radius.
    cycle(0, 0, 0, 0, 1);
    gx[0] = px; gy[0] = py;
    gx[2] = px + 7; gy[2] = py - 7;
    gx[3] = px + 8; gy[3] = py;
    cycle(0, 0, 0, 0, 0);
    ghosts_far();
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Remaining pellets clear the level; restart keeps score and lives.
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    repeat (2) cycle(0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (RT) cycle(0, 1, 0, 0, 0);

    // Two more deaths exhaust the lives.
    die_once();
    repeat (RT) cycle(0, 1, 0, 0, 0);
    die_once();
    repeat (4) cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (RT) cycle(0, 1, 0, 0, 0);

    // Last pellet coincides with a lethal contact.
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    gx[1] = px + 4; gy[1] = py + 4;
    cycle(0, 0, 0, 0, 0);
    ghosts_far();
    cycle(0, 0, 0, 1, 0);
    repeat (DT) cycle(0, 1, 0, 0, 0);
    repeat (RT + 2) cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (RT) cycle(0, 1, 0, 0, 0);

    // Score saturation: eat all four ghosts repeatedly while frightened.
    cycle(0, 0, 0, 0, 1);
    for (int g = 0; g < NG; g++) begin gx[g] = px + g; gy[g] = py; end
    repeat (5) cycle(0, 0, 0, 0, 0);
    ghosts_far();
    repeat (3) cycle(0, 1, 0, 0, 0);

    // Reset in the middle of play.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Random play.
    for (int n = 0; n < 4000; n++) begin
      bit r, t, s, f, p;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          px = $urandom_range(0, 5);
          py = $urandom_range(0, 5);
          for (int g = 0; g < NG; g++) begin
            gx[g] = (1 << XW) - 1 - $urandom_range(0, 5);
            gy[g] = (1 << YW) - 1 - $urandom_range(0, 5);
          end
        end else begin
          px = $urandom_range(0, (1 << XW) - 1);
          py = $urandom_range(0, (1 << YW) - 1);
          for (int g = 0; g < NG; g++) begin
            if ($urandom_range(0, 2) == 0) begin
              gx[g] = clampv(px + $urandom_range(0, 24) - 12, (1 << XW) - 1);
              gy[g] = clampv(py + $urandom_range(0, 24) - 12, (1 << YW) - 1);
            end else begin
              gx[g] = $urandom_range(0, (1 << XW) - 1);
              gy[g] = $urandom_range(0, (1 << YW) - 1);
            end
          end
        end
      end
      r = ($urandom_range(0, 499) == 0);
      t = $urandom_range(0, 1);
      s = ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 39) == 0);
      cycle(r, t, s, f, p);
    end

    ghosts_far();
    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
